uio_bus_sched: RTL and testbench
================================

# uio_bus_sched

Arbiter and sequencer for the shared 8-bit bidirectional `uio` pins of the `tt_um_draft` top. Two internal requesters issue read or write bursts of 1–4 beats. The block grants the bus to one requester at a time and drives `uio_oe`/`uio_out`. It inserts a turnaround cycle whenever the bus direction changes and returns sampled read data to the requester.

## Interface
- `BEATS_W`, default 2: width of each burst-length field; a burst is len+1 beats (1..4 at the default).
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design enable; low blocks new grants.
- `req` in 2: burst request, bit i for requester i.
- `dir` in 2: per requester, 1 = write (drive pins), 0 = read (sample pins).
- `len0`, `len1` in BEATS_W each: beats-1 for requester 0 / 1.
- `wdata0`, `wdata1` in 8 each: write data for requester 0 / 1.
- `uio_in` in 8: pad input path.
- `gnt` out 2: one-hot grant, high for the whole burst including turnaround.
- `beat` out 1: high in each data-beat cycle.
- `done` out 2: one-cycle pulse on the last beat, to the granted requester.
- `rdata` out 8: last sampled `uio_in`.
- `rvalid` out 1: pulse, `rdata` valid.
- `uio_out` out 8: pad output path.
- `uio_oe` out 8: pad enable, 0xFF or 0x00 only.

## Operation
- FSM states: IDLE, TURN, XFER.
- IDLE:
  - If `ena` and any `req`, pick a winner and register `gnt`, the winner's `dir` and `len`.
  - Go to TURN if the winner's dir ≠ `bus_dir`, else go to XFER.
  - Set `bus_dir` to the winner's dir.
- TURN: exactly 1 cycle, `uio_oe`=0x00, no beat; then go to XFER.
- XFER: lasts len+1 cycles, `beat`=1 every cycle, beat counter counts 0..len.
  - Write burst: `uio_oe`=0xFF and `uio_out`=wdata of the granted requester, passed combinationally. The requester advances wdata on each edge where `beat`=1.
  - Read burst: `uio_oe`=0x00; `rdata` <= `uio_in` at each beat edge; `rvalid` pulses the following cycle.
  - Last beat: `done[g]`=1; next state IDLE and `gnt` clears.
- Outside write XFER: `uio_oe`=0x00 and `uio_out`=0x00 (bus parked as input).
- Arbitration is round-robin:
  - 1-bit pointer `last`; on simultaneous requests the requester ≠ `last` wins.
  - A single request wins regardless of `last`.
  - `last` updates at every grant.
- `req`, `dir` and `len` are sampled only in IDLE. Dropping `req` mid-burst is ignored; the burst completes.
- `ena` low: IDLE holds IDLE. A burst already in TURN/XFER completes normally.

## Timing
- Reset values (asynchronous, immediate mid-burst):
  - State IDLE, `bus_dir`=read, `last`=1 (requester 0 wins first).
  - `gnt`=0, `beat`=0, `done`=0, `rvalid`=0, `rdata`=0x00, `uio_out`=0x00, `uio_oe`=0x00.
- Latency:
  - `req` seen at edge k → `gnt` high after edge k.
  - First beat follows edge k, or edge k+1 if a turnaround is needed.
- Minimum one IDLE cycle between bursts, so back-to-back same-direction bursts leave a 1-cycle gap with `uio_oe` low.
- `rvalid`/`rdata` for the last read beat appear one cycle after `done`, i.e. in IDLE.
- No pad ever sees output drive in the cycle immediately after a read beat.

## Configuration
- `UIO_SCHED_FIXED_PRIO_EN` defined: fixed priority; requester 0 always wins simultaneous requests, and `last` is unused.
- Undefined (default): round-robin as above.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0; release, no `req` → outputs stay 0.
- Write from reset: `req`=01, `dir`=01, `len0`=3, wdata0 stepping A1..A4 on beats:
  - `gnt`=01 at cycle 1, TURN with `uio_oe`=00 at cycle 1.
  - Cycles 2–5: `uio_oe`=FF, `uio_out`=A1,A2,A3,A4.
  - `done`=01 at cycle 5; `gnt`=00 at cycle 6.
- Read after write: `req`=10, `dir`=00, `len1`=1, `uio_in`=5A then C3 → TURN, then 2 beats with `uio_oe`=00, `rvalid` twice with `rdata`=5A then C3.
- Contention: `req`=11 held, both write with `len`=0 → grants 01,10,01,10, each a 1-beat burst separated by 1 IDLE cycle. With `UIO_SCHED_FIXED_PRIO_EN`, grants are always 01.
- `ena`=0 with `req`=01 → no grant for 10 cycles. Drop `ena` during a 4-beat burst → burst completes, then no new grant.
- Assert `rst_n`=0 in beat 2 of a write burst → `uio_oe`=00 and `gnt`=00 immediately (before the next clock edge). After release, the next grant goes through TURN if the pending request is a write, since `bus_dir`=read.

Source files
------------

// File: rtl/uio_bus_sched.sv
// uio_bus_sched: round-robin arbiter and burst sequencer for the shared bidirectional uio pins (UIO_SCHED_FIXED_PRIO_EN selects fixed priority)
module uio_bus_sched #(
  parameter int BEATS_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_ena,
  input  logic [1:0]         i_req,
  input  logic [1:0]         i_dir,
  input  logic [BEATS_W-1:0] i_len0,
  input  logic [BEATS_W-1:0] i_len1,
  input  logic [7:0]         i_wdata0,
  input  logic [7:0]         i_wdata1,
  input  logic [7:0]         i_uio_in,
  output logic [1:0]         o_gnt,
  output logic               o_beat,
  output logic [1:0]         o_done,
  output logic [7:0]         o_rdata,
  output logic               o_rvalid,
  output logic [7:0]         o_uio_out,
  output logic [7:0]         o_uio_oe
);
  typedef enum logic [1:0] {IDLE, TURN, XFER} state_t;
  state_t             r_state, w_next;
  logic [1:0]         r_gnt;
  logic               r_dir, r_bus_dir, r_rvalid;
  logic [BEATS_W-1:0] r_len, r_cnt, w_wlen;
  logic [7:0]         r_rdata;
  logic               w_go, w_win, w_wdir, w_last_beat, w_drive;
`ifdef UIO_SCHED_FIXED_PRIO_EN
  assign w_win = ~i_req[0];
`else
  logic r_last;
  assign w_win = (&i_req) ? ~r_last : i_req[1];
  // remember the last winner so a simultaneous request alternates
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last <= 1'b1;
    else if (w_go) r_last <= w_win;
`endif
  assign w_go        = (r_state == IDLE) && i_ena && |i_req;
  assign w_wdir      = i_dir[w_win];
  assign w_wlen      = w_win ? i_len1 : i_len0;
  assign w_last_beat = (r_state == XFER) && (r_cnt == r_len);
  assign w_drive     = (r_state == XFER) && r_dir;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // next state: a direction change costs one turnaround cycle before data
  always_comb begin
    w_next = (r_state == IDLE) ? (w_go ? ((w_wdir != r_bus_dir) ? TURN : XFER) : IDLE) :
             (r_state == TURN) ? XFER :
             (r_state == XFER && !w_last_beat) ? XFER : IDLE;
  end
  // latch the winner's burst parameters at grant and count beats through the burst
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_gnt     <= '0;
      r_dir     <= 1'b0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_bus_dir <= 1'b0;
    end else if (w_go) begin
      r_gnt     <= {w_win, ~w_win};
      r_dir     <= w_wdir;
      r_len     <= w_wlen;
      r_cnt     <= '0;
      r_bus_dir <= w_wdir;
    end else if (r_state == XFER) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_last_beat) r_gnt <= '0;
    end
  // sample the pads on every read beat; rvalid marks the cycle after
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= (r_state == XFER) && !r_dir;
      if ((r_state == XFER) && !r_dir) r_rdata <= i_uio_in;
    end
  // outputs: pads are driven only during write beats, otherwise parked as inputs
  always_comb begin
    o_gnt     = r_gnt;
    o_beat    = (r_state == XFER);
    o_done    = w_last_beat ? r_gnt : 2'b00;
    o_rdata   = r_rdata;
    o_rvalid  = r_rvalid;
    o_uio_oe  = w_drive ? 8'hFF : 8'h00;
    o_uio_out = w_drive ? (r_gnt[1] ? i_wdata1 : i_wdata0) : 8'h00;
  end
endmodule

// File: tb/tb_uio_bus_sched.sv
// tb_uio_bus_sched: directed self-checking bench for uio_bus_sched
module tb_uio_bus_sched;
  logic       clk, rst_n, ena;
  logic [1:0] req, dir, len0, len1;
  logic [7:0] wdata0, wdata1, uio_in;
  logic [1:0] gnt, done;
  logic       beat, rvalid;
  logic [7:0] rdata, uio_out, uio_oe;
  int n_assert = 0;
  int n_fail = 0;

  uio_bus_sched #(.BEATS_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_ena(ena), .i_req(req), .i_dir(dir),
    .i_len0(len0), .i_len1(len1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .i_uio_in(uio_in), .o_gnt(gnt), .o_beat(beat), .o_done(done),
    .o_rdata(rdata), .o_rvalid(rvalid), .o_uio_out(uio_out), .o_uio_oe(uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ena = 1'($urandom); req = 2'($urandom); dir = 2'($urandom);
      len0 = 2'($urandom); len1 = 2'($urandom); wdata0 = 8'($urandom);
      wdata1 = 8'($urandom); uio_in = 8'($urandom);
      step;
      n_assert++;
      if ({gnt, beat, done, rdata, rvalid, uio_out, uio_oe} !== 30'd0) begin
        n_fail++;
        $display("FAIL reset_held: got gnt=%b beat=%b done=%b rdata=%h rvalid=%b out=%h oe=%h, expected all zero", gnt, beat, done, rdata, rvalid, uio_out, uio_oe);
      end
    end
    ena = 1'b1; req = 2'b00; dir = 2'b00; len0 = 2'd0; len1 = 2'd0;
    wdata0 = 8'h00; wdata1 = 8'h00; uio_in = 8'h00;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      n_assert++;
      if ({gnt, beat, done, rdata, rvalid, uio_out, uio_oe} !== 30'd0) begin
        n_fail++;
        $display("FAIL reset_idle: got gnt=%b beat=%b done=%b rdata=%h rvalid=%b out=%h oe=%h, expected all zero", gnt, beat, done, rdata, rvalid, uio_out, uio_oe);
      end
    end
  endtask

  task automatic test_write;
    req = 2'b01; dir = 2'b01; len0 = 2'd3; wdata0 = 8'hA1;
    step;
    n_assert++;
    if (gnt !== 2'b01 || uio_oe !== 8'h00 || beat !== 1'b0) begin
      n_fail++;
      $display("FAIL write_turn: got gnt=%b oe=%h beat=%b, expected 01/00/0", gnt, uio_oe, beat);
    end
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step;
      n_assert++;
      if (uio_oe !== 8'hFF || uio_out !== 8'hA1 + 8'(i) || beat !== 1'b1 || done !== (i == 3 ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL write_beat%0d: got oe=%h out=%h beat=%b done=%b, expected FF/%h/1/%b", i, uio_oe, uio_out, beat, done, 8'hA1 + 8'(i), (i == 3 ? 2'b01 : 2'b00));
      end
      wdata0 = 8'hA2 + 8'(i);
    end
    step;
    n_assert++;
    if (gnt !== 2'b00 || uio_oe !== 8'h00 || done !== 2'b00 || uio_out !== 8'h00) begin
      n_fail++;
      $display("FAIL write_end: got gnt=%b oe=%h done=%b out=%h, expected 00/00/00/00", gnt, uio_oe, done, uio_out);
    end
  endtask

  task automatic test_read;
    req = 2'b10; dir = 2'b00; len1 = 2'd1; uio_in = 8'h5A;
    step;
    n_assert++;
    if (gnt !== 2'b10 || uio_oe !== 8'h00 || beat !== 1'b0) begin
      n_fail++;
      $display("FAIL read_turn: got gnt=%b oe=%h beat=%b, expected 10/00/0", gnt, uio_oe, beat);
    end
    req = 2'b00;
    step;
    n_assert++;
    if (beat !== 1'b1 || uio_oe !== 8'h00 || uio_out !== 8'h00 || rvalid !== 1'b0 || done !== 2'b00) begin
      n_fail++;
      $display("FAIL read_beat0: got beat=%b oe=%h out=%h rvalid=%b done=%b, expected 1/00/00/0/00", beat, uio_oe, uio_out, rvalid, done);
    end
    step;
    n_assert++;
    if (beat !== 1'b1 || uio_oe !== 8'h00 || done !== 2'b10 || rvalid !== 1'b1 || rdata !== 8'h5A) begin
      n_fail++;
      $display("FAIL read_beat1: got beat=%b oe=%h done=%b rvalid=%b rdata=%h, expected 1/00/10/1/5A", beat, uio_oe, done, rvalid, rdata);
    end
    uio_in = 8'hC3;
    step;
    n_assert++;
    if (gnt !== 2'b00 || rvalid !== 1'b1 || rdata !== 8'hC3 || uio_oe !== 8'h00) begin
      n_fail++;
      $display("FAIL read_last_data: got gnt=%b rvalid=%b rdata=%h oe=%h, expected 00/1/C3/00", gnt, rvalid, rdata, uio_oe);
    end
    step;
    n_assert++;
    if (rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_rvalid_end: got rvalid=%b, expected 0", rvalid);
    end
  endtask

  task automatic test_contention;
    logic [1:0] g[4];
    logic [1:0] exp_g[4];
    int nb[4];
    int n;
    logic [1:0] prev;
`ifdef UIO_SCHED_FIXED_PRIO_EN
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    g = '{2'b00, 2'b00, 2'b00, 2'b00};
    nb = '{0, 0, 0, 0};
    n = 0;
    prev = 2'b00;
    req = 2'b11; dir = 2'b11; len0 = 2'd0; len1 = 2'd0;
    for (int c = 0; c < 12; c++) begin
      step;
      if (gnt != 2'b00 && prev == 2'b00) begin
        if (n < 4) g[n] = gnt;
        n++;
      end
      if (beat && n >= 1 && n <= 4) nb[n-1]++;
      prev = gnt;
    end
    n_assert++;
    if (n < 4) begin
      n_fail++;
      $display("FAIL contention_count: got %0d separate grants, expected at least 4", n);
    end
    for (int k = 0; k < 4; k++) begin
      n_assert++;
      if (g[k] !== exp_g[k] || nb[k] !== 1) begin
        n_fail++;
        $display("FAIL contention_grant%0d: got gnt=%b beats=%0d, expected %b/1", k, g[k], nb[k], exp_g[k]);
      end
    end
    req = 2'b00;
    repeat (3) step;
    n_assert++;
    if (gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL contention_settle: got gnt=%b, expected 00", gnt);
    end
  endtask

  task automatic test_ena;
    ena = 1'b0; req = 2'b01; dir = 2'b01; len0 = 2'd3; wdata0 = 8'h00;
    for (int i = 0; i < 10; i++) begin
      step;
      n_assert++;
      if (gnt !== 2'b00 || beat !== 1'b0) begin
        n_fail++;
        $display("FAIL ena_block%0d: got gnt=%b beat=%b, expected 00/0", i, gnt, beat);
      end
    end
    ena = 1'b1;
    step;
    n_assert++;
    if (gnt !== 2'b01 || beat !== 1'b1 || uio_oe !== 8'hFF) begin
      n_fail++;
      $display("FAIL ena_grant: got gnt=%b beat=%b oe=%h, expected 01/1/FF", gnt, beat, uio_oe);
    end
    ena = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step;
      n_assert++;
      if (beat !== 1'b1 || gnt !== 2'b01 || done !== (i == 3 ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL ena_drop_beat%0d: got beat=%b gnt=%b done=%b, expected 1/01/%b", i, beat, gnt, done, (i == 3 ? 2'b01 : 2'b00));
      end
    end
    for (int i = 0; i < 5; i++) begin
      step;
      n_assert++;
      if (gnt !== 2'b00 || beat !== 1'b0) begin
        n_fail++;
        $display("FAIL ena_no_regrant%0d: got gnt=%b beat=%b, expected 00/0", i, gnt, beat);
      end
    end
  endtask

  task automatic test_async_reset;
    ena = 1'b1; req = 2'b01; dir = 2'b01; len0 = 2'd3; wdata0 = 8'h30;
    step;
    step;
    n_assert++;
    if (gnt !== 2'b01 || uio_oe !== 8'hFF || beat !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_beat2: got gnt=%b oe=%h beat=%b, expected 01/FF/1", gnt, uio_oe, beat);
    end
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if (gnt !== 2'b00 || uio_oe !== 8'h00 || beat !== 1'b0 || uio_out !== 8'h00) begin
      n_fail++;
      $display("FAIL arst_immediate: got gnt=%b oe=%h beat=%b out=%h, expected 00/00/0/00", gnt, uio_oe, beat, uio_out);
    end
    step;
    rst_n = 1'b1;
    step;
    n_assert++;
    if (gnt !== 2'b01 || uio_oe !== 8'h00 || beat !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_turn: got gnt=%b oe=%h beat=%b, expected 01/00/0", gnt, uio_oe, beat);
    end
    req = 2'b00;
    step;
    n_assert++;
    if (beat !== 1'b1 || uio_oe !== 8'hFF || uio_out !== 8'h30) begin
      n_fail++;
      $display("FAIL arst_first_beat: got beat=%b oe=%h out=%h, expected 1/FF/30", beat, uio_oe, uio_out);
    end
    repeat (4) step;
    n_assert++;
    if (gnt !== 2'b00 || uio_oe !== 8'h00) begin
      n_fail++;
      $display("FAIL arst_burst_end: got gnt=%b oe=%h, expected 00/00", gnt, uio_oe);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_contention;
    test_ena;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
